// File: rtl/fwd_pkg.sv
// Shared defaults and the match rule used by both the stage and hold-buffer forwarding paths.
package fwd_pkg;

    localparam int XLEN_DEF        = 32;
    localparam int RIDX_DEF        = 5;
    localparam int LANES_DEF       = 2;
    localparam int STAGES_DEF      = 3;
    localparam int LOAD_SHADOW_DEF = 2;
    localparam int HOLD_DEF        = 2;
    localparam int NSRC_DEF        = 2;

    // Widest register index the match function accepts; callers zero-extend into it.
    localparam int RIDX_MAX = 16;

    // A writer forwards to a consumer only if it is live, targets a real register, and targets this one.
    function automatic logic fwd_match(input logic [RIDX_MAX-1:0] idx,
                                       input logic [RIDX_MAX-1:0] tgt,
                                       input logic                valid);
        return valid && (tgt != '0) && (tgt == idx);
    endfunction

endpackage

// File: rtl/fwd_hold_buf.sv
// Stall-hold buffer: captures writeback results while the pipeline is interlocked so that
// writes retiring during a stall stay visible until the register file read catches up.
module fwd_hold_buf
    import fwd_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int RIDX  = RIDX_DEF,
    parameter int LANES = LANES_DEF,
    parameter int HOLD  = HOLD_DEF
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    adv,
    input  logic                                    push,
    input  logic                                    in_valid,
    input  logic [LANES-1:0][RIDX-1:0]              in_tgt,
    input  logic [LANES-1:0][XLEN-1:0]              in_data,
    output logic [HOLD-1:0]                         ent_valid,
    output logic [HOLD-1:0][LANES-1:0][RIDX-1:0]    ent_tgt,
    output logic [HOLD-1:0][LANES-1:0][XLEN-1:0]    ent_data,
    output logic [$clog2(HOLD+1)-1:0]               occ
);

    localparam int OCC_W = $clog2(HOLD+1);

    // Push shifts toward the oldest slot (oldest falls off); a non-stalled advance invalidates everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid <= '0;
            ent_tgt   <= '0;
            ent_data  <= '0;
        end else if (push) begin
            for (int i = HOLD - 1; i > 0; i--) begin
                ent_valid[i] <= ent_valid[i-1];
                ent_tgt[i]   <= ent_tgt[i-1];
                ent_data[i]  <= ent_data[i-1];
            end
            ent_valid[0] <= in_valid;
            ent_tgt[0]   <= in_tgt;
            ent_data[0]  <= in_data;
        end else if (adv) begin
            ent_valid <= '0;
        end
    end

    // Occupancy is a population count of the valid bits.
    always_comb begin
        occ = '0;
        for (int i = 0; i < HOLD; i++) begin
            occ = occ + OCC_W'(ent_valid[i]);
        end
    end

endmodule

// File: rtl/fwd_net.sv
// Execute-stage operand forwarding and load-use interlock. Resolves each source operand from
// in-flight stage results, the stall-hold buffer, or the register-file read; no arithmetic here.
module fwd_net
    import fwd_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int RIDX        = RIDX_DEF,
    parameter int LANES       = LANES_DEF,
    parameter int STAGES      = STAGES_DEF,
    parameter int LOAD_SHADOW = LOAD_SHADOW_DEF,
    parameter int HOLD        = HOLD_DEF,
    parameter int NSRC        = NSRC_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clk_en,
    input  logic                            halt,
    input  logic [STAGES-1:0]               stage_valid,
    input  logic [STAGES-1:0]               stage_is_load,
    input  logic [STAGES*LANES*RIDX-1:0]    stage_tgt,
    input  logic [STAGES*LANES*XLEN-1:0]    stage_data,
    input  logic [NSRC-1:0]                 src_valid,
    input  logic [NSRC*RIDX-1:0]            src_idx,
    input  logic [NSRC*XLEN-1:0]            rf_data,
    output logic [NSRC*XLEN-1:0]            op_data,
    output logic                            stall,
    output logic [$clog2(HOLD+1)-1:0]       hold_occ,
    output logic [31:0]                     stall_cycles
);

    // Stages younger than LOAD_SHADOW carry load results that do not exist yet.
    localparam logic [STAGES-1:0] SHADOW_MASK = STAGES'((64'd1 << LOAD_SHADOW) - 64'd1);

    logic [STAGES-1:0][LANES-1:0][RIDX-1:0]  tgt_s;
    logic [STAGES-1:0][LANES-1:0][XLEN-1:0]  data_s;
    logic [NSRC-1:0][RIDX-1:0]               src_i;
    logic [NSRC-1:0][XLEN-1:0]               rf_i;
    logic [NSRC-1:0][XLEN-1:0]               op_o;
    logic [NSRC-1:0]                         hit;
    logic [STAGES-1:0]                       shadow_load;

    logic                                    adv;
    logic                                    push;
    logic [HOLD-1:0]                         hold_vld;
    logic [HOLD-1:0][LANES-1:0][RIDX-1:0]    hold_tgt;
    logic [HOLD-1:0][LANES-1:0][XLEN-1:0]    hold_data;

    assign tgt_s       = stage_tgt;
    assign data_s      = stage_data;
    assign src_i       = src_idx;
    assign rf_i        = rf_data;
    assign op_data     = op_o;
    assign shadow_load = stage_is_load & SHADOW_MASK;

    assign adv  = clk_en && !halt;
    assign push = adv && stall;

    fwd_hold_buf #(
        .XLEN  (XLEN),
        .RIDX  (RIDX),
        .LANES (LANES),
        .HOLD  (HOLD)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv       (adv),
        .push      (push),
        .in_valid  (stage_valid[STAGES-1]),
        .in_tgt    (tgt_s[STAGES-1]),
        .in_data   (data_s[STAGES-1]),
        .ent_valid (hold_vld),
        .ent_tgt   (hold_tgt),
        .ent_data  (hold_data),
        .occ       (hold_occ)
    );

    // Per-source priority mux: youngest stage/lowest lane first, then newest hold entry, else register file.
    always_comb begin
        op_o = rf_i;
        hit  = '0;
        for (int s = 0; s < NSRC; s++) begin
            for (int k = 0; k < STAGES; k++) begin
                for (int l = 0; l < LANES; l++) begin
                    if (!hit[s] && fwd_match(RIDX_MAX'(src_i[s]), RIDX_MAX'(tgt_s[k][l]), stage_valid[k])) begin
                        op_o[s] = data_s[k][l];
                        hit[s]  = 1'b1;
                    end
                end
            end
            for (int h = 0; h < HOLD; h++) begin
                for (int l = 0; l < LANES; l++) begin
                    if (!hit[s] && fwd_match(RIDX_MAX'(src_i[s]), RIDX_MAX'(hold_tgt[h][l]), hold_vld[h])) begin
                        op_o[s] = hold_data[h][l];
                        hit[s]  = 1'b1;
                    end
                end
            end
        end
    end

    // Load-use interlock looks at every shadow-stage match, independent of which writer wins the mux.
    always_comb begin
        stall = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            for (int k = 0; k < STAGES; k++) begin
                for (int l = 0; l < LANES; l++) begin
                    if (src_valid[s] && shadow_load[k] &&
                        fwd_match(RIDX_MAX'(src_i[s]), RIDX_MAX'(tgt_s[k][l]), stage_valid[k])) begin
                        stall = 1'b1;
                    end
                end
            end
        end
    end

    // Saturating count of cycles where the pipeline tried to advance but was interlocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (push && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_fwd_net.sv
// Self-checking bench for fwd_net: directed scenarios followed by random traffic, all compared
// against a queue-based behavioural model of the forwarding rules.
module tb_fwd_net;

    localparam int XLEN        = 32;
    localparam int RIDX        = 5;
    localparam int LANES       = 2;
    localparam int STAGES      = 3;
    localparam int LOAD_SHADOW = 2;
    localparam int HOLD        = 2;
    localparam int NSRC        = 2;

    typedef struct packed {
        logic                         v;
        logic [LANES-1:0][RIDX-1:0]   t;
        logic [LANES-1:0][XLEN-1:0]   d;
    } ent_t;

    logic                                   clk = 1'b0;
    logic                                   rst_n;
    logic                                   clk_en;
    logic                                   halt;
    logic [STAGES-1:0]                      sv_a;
    logic [STAGES-1:0]                      ld_a;
    logic [STAGES-1:0][LANES-1:0][RIDX-1:0] tgt_a;
    logic [STAGES-1:0][LANES-1:0][XLEN-1:0] data_a;
    logic [NSRC-1:0]                        src_v;
    logic [NSRC-1:0][RIDX-1:0]              src_a;
    logic [NSRC-1:0][XLEN-1:0]              rf_a;
    logic [NSRC-1:0][XLEN-1:0]              op_a;
    logic [NSRC-1:0][XLEN-1:0]              op2_a;
    logic                                   stall_o;
    logic                                   stall2_o;
    logic [1:0]                             occ_o;
    logic [1:0]                             occ2_o;
    logic [31:0]                            cyc_o;
    logic [31:0]                            cyc2_o;

    int              n_assert = 0;
    int              n_fail   = 0;
    ent_t            hq[$];
    longint unsigned m_cnt;
    longint unsigned cnt_before;

    always #5 clk = ~clk;

    fwd_net #(
        .XLEN(XLEN), .RIDX(RIDX), .LANES(LANES), .STAGES(STAGES),
        .LOAD_SHADOW(LOAD_SHADOW), .HOLD(HOLD), .NSRC(NSRC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .halt(halt),
        .stage_valid(sv_a), .stage_is_load(ld_a), .stage_tgt(tgt_a), .stage_data(data_a),
        .src_valid(src_v), .src_idx(src_a), .rf_data(rf_a),
        .op_data(op_a), .stall(stall_o), .hold_occ(occ_o), .stall_cycles(cyc_o)
    );

    // Second instance with a one-stage load shadow; never advances, so its hold buffer stays empty.
    fwd_net #(
        .XLEN(XLEN), .RIDX(RIDX), .LANES(LANES), .STAGES(STAGES),
        .LOAD_SHADOW(1), .HOLD(HOLD), .NSRC(NSRC)
    ) dut_s1 (
        .clk(clk), .rst_n(rst_n), .clk_en(1'b0), .halt(1'b0),
        .stage_valid(sv_a), .stage_is_load(ld_a), .stage_tgt(tgt_a), .stage_data(data_a),
        .src_valid(src_v), .src_idx(src_a), .rf_data(rf_a),
        .op_data(op2_a), .stall(stall2_o), .hold_occ(occ2_o), .stall_cycles(cyc2_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] m_operand(input int s, input bit use_hold);
        logic [RIDX-1:0] idx;
        idx = src_a[s];
        if (idx == '0) return rf_a[s];
        for (int k = 0; k < STAGES; k++)
            for (int l = 0; l < LANES; l++)
                if (sv_a[k] && tgt_a[k][l] == idx) return data_a[k][l];
        if (use_hold)
            foreach (hq[i])
                for (int l = 0; l < LANES; l++)
                    if (hq[i].v && hq[i].t[l] == idx) return hq[i].d[l];
        return rf_a[s];
    endfunction

    function automatic bit m_stall(input int shadow);
        for (int s = 0; s < NSRC; s++)
            if (src_v[s] && src_a[s] != '0)
                for (int k = 0; k < shadow; k++)
                    if (sv_a[k] && ld_a[k])
                        for (int l = 0; l < LANES; l++)
                            if (tgt_a[k][l] == src_a[s]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_occ();
        int n = 0;
        foreach (hq[i]) if (hq[i].v) n++;
        return n;
    endfunction

    task automatic model_reset();
        hq.delete();
        for (int i = 0; i < HOLD; i++) hq.push_back('0);
        m_cnt = 0;
    endtask

    task automatic model_tick();
        ent_t e;
        if (clk_en && !halt) begin
            if (m_stall(LOAD_SHADOW)) begin
                e.v = sv_a[STAGES-1];
                e.t = tgt_a[STAGES-1];
                e.d = data_a[STAGES-1];
                hq.push_front(e);
                void'(hq.pop_back());
                if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            end else begin
                foreach (hq[i]) hq[i].v = 1'b0;
            end
        end
    endtask

    task automatic check_model();
        #1;
        for (int s = 0; s < NSRC; s++) begin
            chk($sformatf("op%0d", s), 64'(op_a[s]), 64'(m_operand(s, 1'b1)));
            chk($sformatf("op%0d_s1", s), 64'(op2_a[s]), 64'(m_operand(s, 1'b0)));
        end
        chk("stall", 64'(stall_o), 64'(m_stall(LOAD_SHADOW)));
        chk("stall_s1", 64'(stall2_o), 64'(m_stall(1)));
        chk("hold_occ", 64'(occ_o), 64'(m_occ()));
        chk("stall_cycles", 64'(cyc_o), m_cnt);
        chk("s1_idle", 64'({occ2_o, cyc2_o}), 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic clear_inputs();
        sv_a   = '0;
        ld_a   = '0;
        tgt_a  = '0;
        data_a = '0;
        src_v  = '0;
        src_a  = '0;
    endtask

    // Stage 0 carries a load of r9 consumed by source 1: guaranteed interlock.
    task automatic force_stall();
        sv_a[0]     = 1'b1;
        ld_a[0]     = 1'b1;
        tgt_a[0][0] = 5'd9;
        src_v[1]    = 1'b1;
        src_a[1]    = 5'd9;
    endtask

    initial begin
        rst_n  = 1'b0;
        clk_en = 1'b0;
        halt   = 1'b0;
        clear_inputs();
        rf_a[0] = 32'hDEAD_0000;
        rf_a[1] = 32'hDEAD_0001;
        model_reset();

        // Reset state
        #3;
        chk("rst_occ", 64'(occ_o), 64'd0);
        chk("rst_cycles", 64'(cyc_o), 64'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_model();

        // Basic priority: stage0 lane1 beats stage2 lane0
        sv_a = 3'b101;
        tgt_a[0][1] = 5'd5; data_a[0][1] = 32'hAA;
        tgt_a[2][0] = 5'd5; data_a[2][0] = 32'hBB;
        src_v[0] = 1'b1; src_a[0] = 5'd5;
        check_model();
        chk("prio_op0", 64'(op_a[0]), 64'h0AA);
        chk("prio_stall", 64'(stall_o), 64'd0);
        tick();

        // Load-use in stage 1
        clear_inputs();
        sv_a[1] = 1'b1; ld_a[1] = 1'b1; tgt_a[1][0] = 5'd7; data_a[1][0] = 32'h77;
        src_v[1] = 1'b1; src_a[1] = 5'd7;
        check_model();
        chk("lu_stall", 64'(stall_o), 64'd1);
        chk("lu_stall_shadow1", 64'(stall2_o), 64'd0);
        src_v[1] = 1'b0;
        check_model();
        chk("lu_stall_srcinv", 64'(stall_o), 64'd0);
        tick();

        // Hold capture: two stalled writebacks of r3
        clear_inputs();
        clk_en = 1'b1;
        force_stall();
        sv_a[2] = 1'b1; tgt_a[2][0] = 5'd3; data_a[2][0] = 32'h11;
        check_model();
        chk("cap_stall", 64'(stall_o), 64'd1);
        tick();
        data_a[2][0] = 32'h22;
        check_model();
        tick();
        clear_inputs();
        src_v[0] = 1'b1; src_a[0] = 5'd3;
        check_model();
        chk("cap_op0", 64'(op_a[0]), 64'h22);
        chk("cap_occ", 64'(occ_o), 64'd2);
        tick();
        check_model();
        chk("cap_occ_clr", 64'(occ_o), 64'd0);
        chk("cap_op0_rf", 64'(op_a[0]), 64'hDEAD_0000);

        // Overflow: three stalled writebacks into a two-deep buffer
        clear_inputs();
        force_stall();
        sv_a[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tgt_a[2][0]  = RIDX'(4 + i);
            data_a[2][0] = 32'(i + 1);
            check_model();
            tick();
        end
        clear_inputs();
        clk_en = 1'b0;
        src_v = 2'b11; src_a[0] = 5'd4; src_a[1] = 5'd5;
        check_model();
        chk("ovf_r4_rf", 64'(op_a[0]), 64'hDEAD_0000);
        chk("ovf_r5", 64'(op_a[1]), 64'd2);
        tick();
        src_a[0] = 5'd6;
        check_model();
        chk("ovf_r6", 64'(op_a[0]), 64'd3);
        chk("ovf_occ", 64'(occ_o), 64'd2);
        chk("ovf_cycles", 64'(cyc_o), 64'd5);

        // Halt with stall pending: no count, no push
        clear_inputs();
        force_stall();
        sv_a[2] = 1'b1; tgt_a[2][0] = 5'd12; data_a[2][0] = 32'hC0FFEE;
        clk_en = 1'b1; halt = 1'b1;
        check_model();
        chk("halt_stall", 64'(stall_o), 64'd1);
        cnt_before = m_cnt;
        tick();
        chk("halt_cycles", 64'(cyc_o), cnt_before);
        chk("halt_occ", 64'(occ_o), 64'd2);

        // Asynchronous reset mid-stall
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_occ", 64'(occ_o), 64'd0);
        chk("arst_cycles", 64'(cyc_o), 64'd0);
        chk("arst_stall", 64'(stall_o), 64'd1);
        rst_n = 1'b1;
        halt  = 1'b0;
        clk_en = 1'b0;
        check_model();
        tick();

        // Register 0 is never forwarded nor interlocked
        sv_a = '1; ld_a = '1; tgt_a = '0;
        for (int k = 0; k < STAGES; k++)
            for (int l = 0; l < LANES; l++) data_a[k][l] = $urandom();
        src_v = 2'b11; src_a = '0;
        rf_a[0] = 32'h1234_5678; rf_a[1] = 32'h9ABC_DEF0;
        check_model();
        chk("r0_op0", 64'(op_a[0]), 64'h1234_5678);
        chk("r0_op1", 64'(op_a[1]), 64'h9ABC_DEF0);
        chk("r0_stall", 64'(stall_o), 64'd0);
        tick();

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            clk_en = ($urandom_range(3, 0) != 0);
            halt   = ($urandom_range(7, 0) == 0);
            for (int k = 0; k < STAGES; k++) begin
                sv_a[k] = 1'($urandom_range(1, 0));
                ld_a[k] = ($urandom_range(3, 0) == 0);
                for (int l = 0; l < LANES; l++) begin
                    tgt_a[k][l]  = RIDX'($urandom_range(7, 0));
                    data_a[k][l] = $urandom();
                end
            end
            for (int s = 0; s < NSRC; s++) begin
                src_v[s] = 1'($urandom_range(1, 0));
                src_a[s] = RIDX'($urandom_range(7, 0));
                rf_a[s]  = $urandom();
            end
            check_model();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_net.md
# fwd_net

Parametrised operand-forwarding and load-use interlock network for the execute stage. It generalises fixed two-lane, three-stage bypassing to any number of stages, write lanes per stage, source operands and hold-buffer depth. It resolves each source operand from in-flight results, a stall-hold buffer or the register-file read, and raises the load-use stall. It sits between decode/register read and the ALU; it performs no arithmetic.

## Interface
- XLEN, 32, data width
- RIDX, 5, register index width; index 0 is never forwarded
- LANES, 2, write lanes per pipeline stage
- STAGES, 3, forwarding stages; stage 0 is youngest (execute output), STAGES-1 is writeback
- LOAD_SHADOW, 2, number of youngest stages whose load results are not yet valid (1..STAGES)
- HOLD, 2, hold-buffer depth; equals register-read latency in cycles (>=1)
- NSRC, 2, source operands per instruction

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clk_en  in  1  pipeline advance enable
- halt  in  1  freeze; state advances only when clk_en && !halt
- stage_valid  in  STAGES  stage holds a real instruction (not bubble)
- stage_is_load  in  STAGES  stage instruction is a load
- stage_tgt  in  STAGES*LANES*RIDX  targets; flattened [stage][lane]
- stage_data  in  STAGES*LANES*XLEN  results, same order
- src_valid  in  NSRC  consumer source is live
- src_idx  in  NSRC*RIDX  consumer source indices
- rf_data  in  NSRC*XLEN  register-file read data
- op_data  out  NSRC*XLEN  resolved operands
- stall  out  1  load-use interlock
- hold_occ  out  $clog2(HOLD+1)  valid hold entries
- stall_cycles  out  32  saturating count of stalled advance cycles

## Operation
- Match: source s matches a (stage, lane) when stage_valid, tgt != 0 and tgt == src_idx[s]. A hold entry matches identically, using its own valid bit.
- Priority per source, first hit wins: stage 0 lane 0, stage 0 lane 1, …, stage STAGES-1 lane LANES-1. Then hold entry 0 (newest) … HOLD-1. Then rf_data. src_idx 0 always yields rf_data.
- Stall: set if, for any s with src_valid[s], a match is found in a stage k < LOAD_SHADOW with stage_is_load[k]. A higher-priority non-load match in a younger stage does not suppress the stall.
- Hold buffer: HOLD entries, each holding a valid bit plus LANES (tgt, data) pairs. Entry 0 is newest.
  - On advance && stall: shift entries down one slot and drop entry HOLD-1. Load entry 0 from stage STAGES-1, with valid = stage_valid[STAGES-1].
  - On advance && !stall: invalidate all entries. No push occurs.
  - When not advancing: hold contents.
- hold_occ: number of entries with the valid bit set.
- stall_cycles: increments on advance && stall and saturates at 2^32-1.

## Timing
- op_data and stall are combinational from the inputs and hold state, with zero latency. There is no path from stall back into the match logic, so no combinational loop exists.
- Hold buffer, hold_occ and stall_cycles update on the rising edge of clk when clk_en && !halt.
- Reset (asynchronous, on rst_n low): all hold entries invalid with targets 0, hold_occ=0, stall_cycles=0. Outputs are valid from the next input evaluation.
- Reset asserted mid-stall: the buffer clears immediately. stall recomputes from the inputs alone.
- When a stall persists longer than HOLD cycles, entries older than HOLD are dropped by design; their writes are already visible in rf_data.
- halt with stall high: stall is still reported. No counter increment and no hold push occur.

## Structure
- Package fwd_pkg: default parameter constants, and a match function (idx, tgt, valid) -> bit used by both the stage and hold match logic.
- Sub-module fwd_hold_buf: HOLD-deep shift register with valid bits, push/clear controls and an occupancy output.
- The top level contains the priority muxes, stall detection and the counter.

## Test plan
- Basic priority: stage0 lane1 tgt=5 data=0xAA, stage2 lane0 tgt=5 data=0xBB, src_idx[0]=5 -> op_data[0]=0xAA, stall=0.
- Load-use: stage1 is_load, tgt=7, src_idx[1]=7, src_valid=1 -> stall=1. Same case with src_valid=0 -> stall=0. Stage1 load with LOAD_SHADOW=1 -> stall=0.
- Hold capture: stall for 2 cycles while stage2 writes r3=0x11 then r3=0x22, then stages clear -> op_data=0x22 and hold_occ=2. The next non-stall advance edge -> hold_occ=0 and op_data=rf_data.
- Overflow: stall for 3 cycles with HOLD=2 and writebacks r4=1, r5=2, r6=3 -> r4 resolves from rf_data, r5=2, r6=3.
- Register 0: tgt=0 in all stages with src_idx=0 -> op_data=rf_data and stall=0, even with is_load set.
- Reset and halt: hold full with halt=1 and stall high -> stall_cycles unchanged. Pulse rst_n low -> hold_occ=0 and stall_cycles=0 immediately.
